cc_unit: RTL
============

Name: cc_unit

Overview:
- Producer side of the condition-code interface: captures N/Z/C/V from the EX-stage ALU on flag-setting (S=1) instructions.
- Carries pending flag updates through the MEM and WB pipeline slots and commits them to the architectural CC register at WB.
- Drives forwarded Z_CC/N_CC/C_CC/V_CC to the condition handler, so a branch always sees the youngest non-flushed flag value.
- Sits beside the EX/MEM/WB pipeline registers and obeys the same stall/flush controls.

Parameters:
- CC_RESET, 4'b0000, architectural {N,Z,C,V} value loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freeze EX->MEM->WB flag slots and architectural commit.
- flush  in  1  kill the EX input and the MEM slot; takes priority over stall.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_s  in  1  EX instruction sets flags.
- ex_n, ex_z, ex_c, ex_v  in  1 each  ALU flags of the EX instruction.
- N_CC, Z_CC, C_CC, V_CC  out  1 each  forwarded flags to the condition handler.
- cc_arch  out  4  committed {N,Z,C,V}.
- cc_src  out  2  forwarding source: 0=arch, 1=WB slot, 2=MEM slot, 3=EX.
- cc_commit  out  1  pulses high in a cycle where cc_arch is written at the next edge.

Behaviour:
- State:
  - mem_slot is {valid, flags[3:0]}.
  - wb_slot is {valid, flags[3:0]}.
  - arch is 4 bits.
- Reset (synchronous, highest priority):
  - mem_slot.valid=0, wb_slot.valid=0, arch=CC_RESET; slot flag bits are cleared to 0.
  - Outputs in the cycle after reset: N/Z/C/V_CC = CC_RESET, cc_src=0, cc_commit=0, cc_arch=CC_RESET.
- ex_take = ex_valid & ex_s & ~flush (combinational).
- Edge, flush=1 (stall ignored):
  - mem_slot.valid <= 0.
  - wb_slot <= mem_slot is NOT performed: the MEM entry is discarded.
  - wb_slot and arch advance as in the non-stalled case (wb_slot commits, then wb_slot.valid <= 0).
- Edge, flush=0, stall=1: mem_slot, wb_slot and arch all hold.
- Edge, flush=0, stall=0:
  - mem_slot <= {ex_take, ex flags}.
  - wb_slot <= mem_slot.
  - if wb_slot.valid, arch <= wb_slot.flags.
- cc_commit = wb_slot.valid & (~stall | flush).
- Commit latency: flags of an S instruction in EX at edge k reach cc_arch after edge k+2 with no stalls. Each stalled cycle adds one cycle.
- Forwarding (combinational), priority EX > MEM > WB > arch:
  - if ex_take: flags = ex_*, cc_src=3.
  - else if mem_slot.valid: flags = mem_slot, cc_src=2.
  - else if wb_slot.valid: flags = wb_slot, cc_src=1.
  - else flags = arch, cc_src=0.
- Non-S instructions (ex_s=0) and bubbles (ex_valid=0) insert invalid slots and never modify arch.
- Back-to-back S instructions: each commits in order; the youngest is always the forwarded value.
- Reset mid-operation discards all in-flight updates; no partial commit.
- Flag bits are written verbatim; there is no arithmetic on them.

Test Plan:
- Reset with CC_RESET=4'b0100 -> next cycle Z_CC=1, N/C/V_CC=0, cc_src=0, cc_commit=0.
- EX S-instruction with flags 4'b1000, then two bubbles:
  - cycle0 cc_src=3, N_CC=1; cycle1 cc_src=2; cycle2 cc_src=1, cc_commit=1.
  - cycle3 cc_arch=4'b1000, cc_src=0.
- Back-to-back S instructions with flags 4'b0100 then 4'b0010:
  - forwarded value equals 4'b0010 from the second cycle on.
  - cc_arch steps 4'b0100 then 4'b0010 on consecutive edges.
- S instruction in MEM slot with flags 4'b0001 and flush=1 for one cycle:
  - the slot is dropped; cc_arch never becomes 4'b0001.
  - the older WB entry still commits.
- stall=1 for 3 cycles with a valid WB slot of 4'b0110:
  - cc_arch holds, cc_commit=0, cc_src=1 throughout.
  - after release, cc_arch=4'b0110.
- ex_valid=1, ex_s=0 with ex flags 4'b1111 -> no forwarding from EX; cc_arch unchanged after 3 cycles.
- reset asserted while MEM and WB slots are valid -> both invalidated; cc_arch=CC_RESET next cycle.

Source files
------------

// File: rtl/cc_unit.sv
// Condition-code producer: carries N/Z/C/V updates from EX through MEM and WB,
// commits them to the architectural CC register and forwards the youngest value.
module cc_unit #(
  parameter logic [3:0] CC_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       ex_valid,
  input  logic       ex_s,
  input  logic       ex_n,
  input  logic       ex_z,
  input  logic       ex_c,
  input  logic       ex_v,
  output logic       N_CC,
  output logic       Z_CC,
  output logic       C_CC,
  output logic       V_CC,
  output logic [3:0] cc_arch,
  output logic [1:0] cc_src,
  output logic       cc_commit
);

  typedef enum logic [1:0] {
    SRC_ARCH = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MEM  = 2'd2,
    SRC_EX   = 2'd3
  } cc_src_e;

  logic       mem_valid;
  logic [3:0] mem_flags;
  logic       wb_valid;
  logic [3:0] wb_flags;
  logic [3:0] arch;

  logic       ex_take;
  logic [3:0] ex_flags;
  logic [3:0] fwd_flags;
  cc_src_e    fwd_src;

  assign ex_take  = ex_valid & ex_s & ~flush;
  assign ex_flags = {ex_n, ex_z, ex_c, ex_v};

  // Flush drops the MEM entry but still lets the older WB entry commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_flags <= 4'b0000;
      wb_valid  <= 1'b0;
      wb_flags  <= 4'b0000;
      arch      <= CC_RESET;
    end else if (flush) begin
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      if (wb_valid) begin
        arch <= wb_flags;
      end
    end else if (!stall) begin
      mem_valid <= ex_take;
      mem_flags <= ex_flags;
      wb_valid  <= mem_valid;
      wb_flags  <= mem_flags;
      if (wb_valid) begin
        arch <= wb_flags;
      end
    end
  end

  // Youngest non-flushed producer wins: EX, then MEM, then WB, then arch.
  always_comb begin
    fwd_flags = arch;
    fwd_src   = SRC_ARCH;
    if (ex_take) begin
      fwd_flags = ex_flags;
      fwd_src   = SRC_EX;
    end else if (mem_valid) begin
      fwd_flags = mem_flags;
      fwd_src   = SRC_MEM;
    end else if (wb_valid) begin
      fwd_flags = wb_flags;
      fwd_src   = SRC_WB;
    end
  end

  assign N_CC      = fwd_flags[3];
  assign Z_CC      = fwd_flags[2];
  assign C_CC      = fwd_flags[1];
  assign V_CC      = fwd_flags[0];
  assign cc_src    = fwd_src;
  assign cc_arch   = arch;
  assign cc_commit = wb_valid & (~stall | flush);

endmodule
